// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte per request (e.g. 0xED LED, 0xFF reset). The block
// inhibits the bus, issues a start bit, then the device generates the clock.
// On each device falling edge the next bit goes onto the data line. After
// the stop bit the device's ACK is sampled. Both pins are open-drain: the
// *_oe outputs pull a line low when 1.
//
// Ports
//   clock, reset            system clock, async active-high reset
//   tx_valid/tx_data/tx_ready  request handshake (byte accepted when valid&&ready)
//   ps2_clk_in/ps2_data_in  raw pin levels (asynchronous, synchronized here)
//   ps2_clk_oe/ps2_data_oe  open-drain pull-low enables
//   busy                    transaction in flight; the receiver ignores the bus
//   tx_done                 one-cycle pulse at the end of every transaction
//   tx_ack_ok               with tx_done: device ACKed the byte
//   tx_error                with tx_done: aborted by device-clock timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]       state;
  logic [1:0]       clk_sync, data_sync;
  logic             clk_q;
  logic             clk_s, data_s, fe;
  logic [7:0]       shreg;
  logic             par;
  logic             ack;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             in_frame;

  // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_q     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_q     <= clk_sync[1];
    end
  end

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign fe       = clk_q & ~clk_s;
  assign tx_ready = (state == S_IDLE) && !reset;
  assign in_frame = (state == S_START) || (state == S_SEND) ||
                    (state == S_ACK)   || (state == S_WAIT_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_ack_ok   <= 1'b0;
      tx_error    <= 1'b0;
      shreg       <= '0;
      par         <= 1'b0;
      ack         <= 1'b0;
      bit_idx     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      tx_done   <= 1'b0;
      tx_ack_ok <= 1'b0;
      tx_error  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shreg       <= tx_data;
            par         <= ~^tx_data;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            inh_cnt     <= '0;
            state       <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            // Release clock and pull data low together: the start bit.
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            to_cnt      <= '0;
            state       <= S_START;
          end else if (inh_cnt != '1) begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        S_START: begin
          bit_idx <= '0;
          state   <= S_SEND;
        end
        S_SEND: begin
          // Falling edges 1..8 carry data LSB first, 9 parity, 10 the stop bit.
          if (fe) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx < 4'd8) begin
              ps2_data_oe <= ~shreg[bit_idx[2:0]];
            end else if (bit_idx == 4'd8) begin
              ps2_data_oe <= ~par;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (fe) begin
            ack   <= ~data_s;
            state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_s && data_s) state <= S_DONE;
        end
        S_DONE: begin
          tx_done   <= 1'b1;
          tx_ack_ok <= ack;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Device-clock watchdog; placed after the case so an abort overrides
      // whatever the frame states scheduled this cycle.
      if (in_frame) begin
        if (fe) begin
          to_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          tx_done     <= 1'b1;
          tx_error    <= 1'b1;
          tx_ack_ok   <= 1'b0;
          state       <= S_IDLE;
        end else if (to_cnt != '1) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule
